// File: rtl/mux_gate_sched_pkg.sv
// Shared types and default sizing for the mux-built bit-serial gate scheduler.
package mux_gate_sched_pkg;

  localparam int unsigned N_REQ_DEFAULT = 4;
  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

endpackage

// File: rtl/mux_gate_scheduler_if.sv
// Request/response bundle between N_REQ requesters, one consumer and the scheduler.
interface mux_gate_scheduler_if #(
    parameter int unsigned N_REQ = mux_gate_sched_pkg::N_REQ_DEFAULT,
    parameter int unsigned WIDTH = mux_gate_sched_pkg::WIDTH_DEFAULT
);
    localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0][WIDTH-1:0] req_a;
    logic [N_REQ-1:0][WIDTH-1:0] req_b;
    logic [N_REQ-1:0][1:0]       req_op;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [WIDTH-1:0]            rsp_data;
    logic [IdW-1:0]              rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/mux_gate_bit.sv
// One-bit AND/OR/XOR/XNOR gate built purely from 2:1 muxes and constants.
module mux_gate_bit (
    input  logic       a,
    input  logic       b,
    input  logic [1:0] op,
    output logic       y
);
    logic nb, y_and, y_or, y_xor, y_xnor, y_lo, y_hi;

    // a selects between the b-derived inputs for each function
    mux_gate_mux2 u_nb   (.d0(1'b1),  .d1(1'b0),   .s(b),     .y(nb));
    mux_gate_mux2 u_and  (.d0(1'b0),  .d1(b),      .s(a),     .y(y_and));
    mux_gate_mux2 u_or   (.d0(b),     .d1(1'b1),   .s(a),     .y(y_or));
    mux_gate_mux2 u_xor  (.d0(b),     .d1(nb),     .s(a),     .y(y_xor));
    mux_gate_mux2 u_xnor (.d0(nb),    .d1(b),      .s(a),     .y(y_xnor));
    mux_gate_mux2 u_lo   (.d0(y_and), .d1(y_or),   .s(op[0]), .y(y_lo));
    mux_gate_mux2 u_hi   (.d0(y_xor), .d1(y_xnor), .s(op[0]), .y(y_hi));
    mux_gate_mux2 u_out  (.d0(y_lo),  .d1(y_hi),   .s(op[1]), .y(y));
endmodule

// File: rtl/mux_gate_mux2.sv
// Two-input multiplexer: the only primitive the gate unit is built from.
module mux_gate_mux2 (
    input  logic d0,
    input  logic d1,
    input  logic s,
    output logic y
);
    assign y = s ? d1 : d0;
endmodule

// File: rtl/mux_gate_scheduler.sv
// Arbitrates N_REQ requesters onto one shared bit-serial gate unit, LSB first.
// Define MUX_GATE_SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module mux_gate_scheduler
    import mux_gate_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input logic                 clk,
    input logic                 rst_n,
    mux_gate_scheduler_if.slave bus
);
    localparam int unsigned      IdW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned      CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [IdW-1:0]   id_q;
    logic [CntW-1:0]  cnt_q;
    logic             rsp_valid_q;
    logic             grant_found;
    logic [IdW-1:0]   grant_idx;
    logic [N_REQ-1:0] req_ready;
    logic             bit_y;
`ifdef MUX_GATE_SCHED_RR_EN
    logic [IdW-1:0]   ptr_q;
`endif

    // Descending loops so the lowest qualifying index is the last (winning) write.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = IdW'(i);
            end
        end
`ifdef MUX_GATE_SCHED_RR_EN
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (IdW'(i) >= ptr_q)) begin
                grant_idx = IdW'(i);
            end
        end
`endif
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            req_ready[i] = rst_n && (state_q == IDLE) && grant_found && (grant_idx == IdW'(i));
        end
    end

    mux_gate_bit u_gate (
        .a  (a_q[cnt_q]),
        .b  (b_q[cnt_q]),
        .op (op_q),
        .y  (bit_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
`ifdef MUX_GATE_SCHED_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        a_q     <= bus.req_a[grant_idx];
                        b_q     <= bus.req_b[grant_idx];
                        op_q    <= op_e'(bus.req_op[grant_idx]);
                        id_q    <= grant_idx;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        state_q <= BUSY;
`ifdef MUX_GATE_SCHED_RR_EN
                        ptr_q   <= (grant_idx == IdW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
                    end
                end
                BUSY: begin
                    res_q[cnt_q] <= bit_y;
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        res_q       <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_valid_q ? res_q : '0;
    assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_mux_gate_scheduler.sv
// Directed bench for mux_gate_scheduler; expected responses are queued and checked by a monitor.
module tb_mux_gate_scheduler;
    localparam int unsigned NR = 4;
    localparam int unsigned W  = 8;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cycle;
    int   checks;
    int   failures;
    int   exp_rise;
    logic valid_prev;
    exp_t exp_q[$];
    exp_t mon_e;

    mux_gate_scheduler_if #(.N_REQ(NR), .WIDTH(W)) bus ();

    mux_gate_scheduler #(.N_REQ(NR), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 1 time unit after the falling edge.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.rsp_valid && !valid_prev && exp_rise != 0)
                chk("rsp_latency", cycle, exp_rise);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", bus.rsp_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_data", bus.rsp_data, mon_e.data);
                    chk("rsp_id", bus.rsp_id, mon_e.id);
                end
            end
        end
        valid_prev = bus.rsp_valid;
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single request: check grant, queue expectation, drop valid after the accept edge.
    task automatic issue(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [7:0] exp);
        exp_t e;
        @(negedge clk);
        bus.req_a[r]     = a;
        bus.req_b[r]     = b;
        bus.req_op[r]    = op;
        bus.req_valid    = '0;
        bus.req_valid[r] = 1'b1;
        #1;
        chk("req_ready_grant", bus.req_ready, 32'(1) << r);
        e.id     = 2'(r);
        e.data   = exp;
        exp_q.push_back(e);
        exp_rise = cycle + 1 + int'(W);
        @(negedge clk);
        #1;
        chk("req_ready_busy", bus.req_ready, 0);
        bus.req_valid = '0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        exp_t e;
        int   n;
        cycle         = 0;
        checks        = 0;
        failures      = 0;
        exp_rise      = 0;
        valid_prev    = 1'b0;
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, with all requesters pending
        #2;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_no_valid_ready", bus.req_ready, 0);
        repeat (2) @(negedge clk);
        chk("idle_stays_quiet", bus.rsp_valid, 0);

        // Basic operations on several requesters
        issue(0, 8'hA5, 8'h0F, 2'b10, 8'hAA);
        drain(40);
        issue(2, 8'hF0, 8'h3C, 2'b00, 8'h30);
        drain(40);
        issue(2, 8'hF0, 8'h3C, 2'b01, 8'hFC);
        drain(40);
        issue(2, 8'hF0, 8'h3C, 2'b11, 8'h33);
        drain(40);
        issue(3, 8'h5A, 8'h33, 2'b00, 8'h12);
        drain(40);
        issue(1, 8'h00, 8'h00, 2'b11, 8'hFF);
        drain(40);

        // All four requesters held valid after reset
        reset_dut();
        exp_rise = 0;
        for (int r = 0; r < int'(NR); r++) begin
            bus.req_a[r]  = 8'(8'h11 * (r + 1));
            bus.req_b[r]  = 8'h00;
            bus.req_op[r] = 2'b01;
        end
`ifdef MUX_GATE_SCHED_RR_EN
        for (int k = 0; k < 5; k++) begin
            e.id   = 2'(k % 4);
            e.data = 8'(8'h11 * ((k % 4) + 1));
            exp_q.push_back(e);
        end
`else
        for (int k = 0; k < 5; k++) begin
            e.id   = 2'd0;
            e.data = 8'h11;
            exp_q.push_back(e);
        end
`endif
        @(negedge clk);
        bus.req_valid = '1;
        drain(120);
        bus.req_valid = '0;

        // Consumer stall in DONE
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        issue(1, 8'h81, 8'h18, 2'b01, 8'h99);
        n = 0;
        while (!bus.rsp_valid && n < 30) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("stall_rsp_seen", bus.rsp_valid, 1);
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #2;
            chk("stall_rsp_valid", bus.rsp_valid, 1);
            chk("stall_rsp_data", bus.rsp_data, 8'h99);
            chk("stall_rsp_id", bus.rsp_id, 1);
            chk("stall_req_ready", bus.req_ready, 0);
        end
        @(negedge clk);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        drain(10);

        // Reset while bit 3 is being computed
        @(negedge clk);
        bus.req_a[2]  = 8'hFF;
        bus.req_b[2]  = 8'hFF;
        bus.req_op[2] = 2'b00;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        #2;
        bus.req_valid = '1;
        rst_n         = 1'b0;
        #1;
        chk("midrst_req_ready", bus.req_ready, 0);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_rsp_data", bus.rsp_data, 0);
        chk("midrst_rsp_id", bus.rsp_id, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("postrst_grant_ptr0", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #2;
            if (bus.rsp_valid) n++;
        end
        chk("postrst_no_stale_rsp", n, 0);

        // Recovery after the aborted operation
        issue(0, 8'h0F, 8'hFF, 2'b11, 8'h0F);
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux_gate_scheduler.md
MUX_GATE_SCHEDULER -- requirements
Module: mux_gate_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the bit-serial gate unit (2..8).
REQ-002 Parameter WIDTH, default 8: operand and result width in bits (2..32).
REQ-003 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  N_REQ  per-requester "operation pending".
REQ-006 req_ready  output  N_REQ  per-requester accept; at most one bit set.
REQ-007 req_a, req_b  input  N_REQ x WIDTH each  per-requester operands.
REQ-008 req_op  input  N_REQ x 2  per-requester opcode: 00 AND, 01 OR, 10 XOR, 11 XNOR.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_data  output  WIDTH  result word.
REQ-012 rsp_id  output  clog2(N_REQ)  index of the requester that issued the result.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 In IDLE, the arbiter SHALL grant one valid requester; req_ready[g] = (state==IDLE) & grant[g], combinational.
REQ-015 On an accept edge (req_valid[g] & req_ready[g]), the block SHALL latch a, b, op and g, clear the bit counter, and go to BUSY.
REQ-016 BUSY SHALL compute one result bit per cycle, LSB first, through the gate unit; the bit counter runs 0..WIDTH-1.
REQ-017 After the edge that computes bit WIDTH-1, the FSM SHALL enter DONE, so rsp_valid rises exactly WIDTH cycles after the accept edge.
REQ-018 DONE SHALL hold rsp_valid=1 with rsp_data and rsp_id stable until rsp_valid & rsp_ready; that edge returns the FSM to IDLE.
REQ-019 No req_ready bit SHALL assert in BUSY or DONE; a new grant is possible in the first IDLE cycle after the response handshake.
REQ-020 rsp_data SHALL be 0 and rsp_valid SHALL be 0 outside DONE.
REQ-021 If no req_valid bit is set in IDLE, the FSM SHALL stay in IDLE and all req_ready bits SHALL be 0.
REQ-022 Deasserting req_valid after acceptance SHALL have no effect; operands come from the latched copy.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, counter 0, priority pointer 0, result register 0, rsp_valid 0, and all req_ready bits 0, regardless of clk.
REQ-024 Reset during BUSY or DONE SHALL discard the operation; no response is emitted for it.

Configuration
REQ-025 With MUX_GATE_SCHED_RR_EN defined, arbitration SHALL be round-robin: search starts at the priority pointer, and the pointer becomes (g+1) mod N_REQ on each accept.
REQ-026 Without MUX_GATE_SCHED_RR_EN, arbitration SHALL be fixed priority: the lowest valid index wins, and no pointer register exists.

Structure
REQ-027 A shared package mux_gate_sched_pkg SHALL hold the state enum (IDLE/BUSY/DONE), the opcode enum (OP_AND/OP_OR/OP_XOR/OP_XNOR) and the default parameter constants.
REQ-028 The one-bit gate SHALL be a sub-module mux_gate_bit (inputs a, b, op[1:0]; output y), built only from mux instances and the constants 0/1.
REQ-029 mux_gate_bit SHALL be purely combinational; it is instantiated exactly once and shared by all requesters.

Verification (N_REQ=4, WIDTH=8)
REQ-030 Requester 0: a=8'hA5, b=8'h0F, op XOR -> rsp_data 8'hAA, rsp_id 0, rsp_valid exactly 8 cycles after the accept edge.
REQ-031 Requester 2: a=8'hF0, b=8'h3C, run AND, OR, XNOR in turn -> 8'h30, 8'hFC, 8'h33, each with rsp_id 2.
REQ-032 All four requesters held valid after reset, rsp_ready=1:
  - with the macro -> grant order 0,1,2,3,0;
  - without it -> requester 0 wins every time.
REQ-033 rsp_ready held low 5 cycles in DONE -> rsp_valid, rsp_data and rsp_id are stable, and req_ready stays 0 throughout.
REQ-034 rst_n pulsed low while bit 3 of BUSY is computing -> outputs are 0 asynchronously; after release the FSM is in IDLE, the pointer is 0, and no stale response ever appears.
